// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement monitor.
// Watches the retirement channels of the core under test. Each channel is
// checked against its spec model for completeness, for contiguous order
// numbering, for PC continuity and for retiring after a halt. A liveness
// timeout also runs while the core is not halted. The first violation is
// latched, and retirements are counted.
module rvfi_retire_monitor #(
  parameter int NRET        = 1,
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 32,
  parameter int SKIP_SYSTEM = 1
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NRET-1:0]                       rvfi_valid,
  input  logic [64*NRET-1:0]                    rvfi_order,
  input  logic [32*NRET-1:0]                    rvfi_insn,
  input  logic [NRET-1:0]                       rvfi_trap,
  input  logic [NRET-1:0]                       rvfi_halt,
  input  logic [XLEN*NRET-1:0]                  rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]                  rvfi_pc_wdata,
  input  logic [NRET-1:0]                       spec_valid,
  input  logic [NRET-1:0]                       spec_trap,
  output logic                                  err,
  output logic [2:0]                            err_code,
  output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] err_chan,
  output logic [63:0]                           err_order,
  output logic [CNT_W-1:0]                      retire_cnt,
  output logic                                  halted
);

  localparam int CH_W   = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int POP_W  = $clog2(NRET + 1);

  localparam logic [2:0] E_INCOMPLETE = 3'd1;
  localparam logic [2:0] E_GAP        = 3'd2;
  localparam logic [2:0] E_ORDER      = 3'd3;
  localparam logic [2:0] E_PC         = 3'd4;
  localparam logic [2:0] E_TIMEOUT    = 3'd5;
  localparam logic [2:0] E_AFTER_HALT = 3'd6;

  // Number of channels retiring this cycle.
  function automatic logic [POP_W-1:0] popcount(input logic [NRET-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < NRET; i++) begin
      s = s + POP_W'(v[i]);
    end
    return s;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W + 1 - POP_W){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Architectural tracking state.
  logic [63:0]       expected_order;
  logic [XLEN-1:0]   last_pc;
  logic              last_trap;
  logic              last_pc_valid;
  logic [IDLE_W-1:0] idle_cnt;

  // Per-cycle decode results.
  logic              viol_p0;
  logic [2:0]        viol_code_p0;
  logic [CH_W-1:0]   viol_chan_p0;
  logic [63:0]       viol_order_p0;
  logic [XLEN-1:0]   pred_pc_p0;
  logic              pred_trap_p0;
  logic              pred_ok_p0;
  logic              halt_seen_p0;
  logic              prev_valid_p0;
  logic [2:0]        code_k_p0;
  logic [63:0]       order_k_p0;
  logic [31:0]       insn_k_p0;
  logic              any_valid_p0;
  logic              halt_any_p0;
  logic [POP_W-1:0]  pop_p0;
  logic              timeout_hit_p0;

  assign any_valid_p0   = |rvfi_valid;
  assign halt_any_p0    = |(rvfi_valid & rvfi_halt);
  assign pop_p0         = popcount(rvfi_valid);
  assign timeout_hit_p0 = (TIMEOUT != 0) && !halted && (idle_cnt == IDLE_W'(TIMEOUT));

  // ---- stage p0: classify every channel, pick the first violation ----
  // Within a channel the lowest code wins, so checks are applied from the
  // highest code down and lower codes overwrite. The predecessor PC walks
  // through the active channels, so after the loop it holds the values of
  // the highest active channel.
  always_comb begin
    viol_p0       = 1'b0;
    viol_code_p0  = '0;
    viol_chan_p0  = '0;
    viol_order_p0 = '0;
    pred_pc_p0    = last_pc;
    pred_trap_p0  = last_trap;
    pred_ok_p0    = last_pc_valid;
    halt_seen_p0  = halted;
    prev_valid_p0 = 1'b1;
    code_k_p0     = '0;
    order_k_p0    = '0;
    insn_k_p0     = '0;
    for (int k = 0; k < NRET; k++) begin
      code_k_p0  = '0;
      order_k_p0 = rvfi_order[k*64 +: 64];
      insn_k_p0  = rvfi_insn[k*32 +: 32];
      if (rvfi_valid[k]) begin
        if (halt_seen_p0)
          code_k_p0 = E_AFTER_HALT;
        if (pred_ok_p0 && !pred_trap_p0 && (rvfi_pc_rdata[k*XLEN +: XLEN] != pred_pc_p0))
          code_k_p0 = E_PC;
        if (order_k_p0 != expected_order + 64'(k))
          code_k_p0 = E_ORDER;
        if (!prev_valid_p0)
          code_k_p0 = E_GAP;
        if (!rvfi_trap[k] && !((SKIP_SYSTEM != 0) && (insn_k_p0[6:0] == 7'b1110011))
            && !(spec_valid[k] && !spec_trap[k]))
          code_k_p0 = E_INCOMPLETE;
        pred_pc_p0   = rvfi_pc_wdata[k*XLEN +: XLEN];
        pred_trap_p0 = rvfi_trap[k];
        pred_ok_p0   = 1'b1;
        if (rvfi_halt[k])
          halt_seen_p0 = 1'b1;
      end
      // The liveness error is attributed to channel 0.
      if ((k == 0) && timeout_hit_p0 && ((code_k_p0 == 3'd0) || (code_k_p0 > E_TIMEOUT))) begin
        code_k_p0  = E_TIMEOUT;
        order_k_p0 = expected_order;
      end
      if (!viol_p0 && (code_k_p0 != 3'd0)) begin
        viol_p0       = 1'b1;
        viol_code_p0  = code_k_p0;
        viol_chan_p0  = CH_W'(k);
        viol_order_p0 = order_k_p0;
      end
      prev_valid_p0 = rvfi_valid[k];
    end
  end

  // ---- stage p1: sticky error capture and control state ----
  // Control state: first-error capture, order tracking, counters, halt flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err            <= 1'b0;
      err_code       <= '0;
      err_chan       <= '0;
      err_order      <= '0;
      retire_cnt     <= '0;
      halted         <= 1'b0;
      expected_order <= '0;
      last_pc_valid  <= 1'b0;
      idle_cnt       <= '0;
    end else begin
      if (!err && viol_p0) begin
        err       <= 1'b1;
        err_code  <= viol_code_p0;
        err_chan  <= viol_chan_p0;
        err_order <= viol_order_p0;
      end
      if (any_valid_p0) begin
        expected_order <= expected_order + 64'(pop_p0);
        retire_cnt     <= sat_add(retire_cnt, pop_p0);
        last_pc_valid  <= 1'b1;
        idle_cnt       <= '0;
        if (halt_any_p0)
          halted <= 1'b1;
      end else if ((TIMEOUT != 0) && !halted && (idle_cnt != IDLE_W'(TIMEOUT))) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // Predecessor PC/trap of the last retiring cycle; qualified by last_pc_valid.
  always_ff @(posedge clk) begin
    if (resetn && any_valid_p0) begin
      last_pc   <= pred_pc_p0;
      last_trap <= pred_trap_p0;
    end
  end

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Bench for rvfi_retire_monitor (two channels, 16-cycle liveness window,
// 6-bit retire counter so saturation is reachable).
module tb_rvfi_retire_monitor;

  localparam int NRET    = 2;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 6;
  localparam logic [31:0] ADDI  = 32'h0000_0013;
  localparam logic [31:0] ADD   = 32'h0000_0033;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    rvfi_valid, rvfi_trap, rvfi_halt, spec_valid, spec_trap;
  logic [127:0]  rvfi_order;
  logic [63:0]   rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
  logic          err, halted;
  logic [2:0]    err_code;
  logic [0:0]    err_chan;
  logic [63:0]   err_order;
  logic [5:0]    retire_cnt;

  always #5 clk = ~clk;

  rvfi_retire_monitor #(.NRET(NRET), .XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
                        .SKIP_SYSTEM(1)) dut (
    .clk(clk), .resetn(resetn), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .spec_valid(spec_valid), .spec_trap(spec_trap), .err(err), .err_code(err_code),
    .err_chan(err_chan), .err_order(err_order), .retire_cnt(retire_cnt), .halted(halted));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state.
  logic        m_err, m_halted, m_last_trap, m_have_last;
  int          m_code, m_chan, m_cnt, m_idle;
  logic [63:0] m_order, m_exp;
  logic [31:0] m_last_pc;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] ord0, ord1;
    logic [31:0] insn0, insn1;
    logic [1:0]  trap, halt, sv, st;
    logic [31:0] pcr0, pcw0, pcr1, pcw1;
    logic        e_err;
    logic [2:0]  e_code;
    logic        e_chan;
    logic [63:0] e_order;
    logic [5:0]  e_cnt;
    logic        e_halted;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void model_step();
    int best_code, best_chan, n, c;
    logic [63:0] best_order, o;
    logic [31:0] ppc, insn;
    logic ptrap, phave, hb, any_halt;
    if (!resetn) begin
      m_err = 0; m_code = 0; m_chan = 0; m_order = 0; m_cnt = 0; m_halted = 0;
      m_exp = 0; m_have_last = 0; m_idle = 0; m_last_pc = 0; m_last_trap = 0;
      return;
    end
    best_code = 0; best_chan = 0; best_order = 0; n = 0;
    ppc = m_last_pc; ptrap = m_last_trap; phave = m_have_last;
    hb = m_halted; any_halt = 0;
    for (int k = 0; k < NRET; k++) begin
      c = 0;
      o = rvfi_order[k*64 +: 64];
      insn = rvfi_insn[k*32 +: 32];
      if (rvfi_valid[k]) begin
        n++;
        if (!rvfi_trap[k] && insn[6:0] != 7'h73 && !(spec_valid[k] && !spec_trap[k])) c = 1;
        else if (k > 0 && !rvfi_valid[(k > 0) ? k - 1 : 0]) c = 2;
        else if (o != m_exp + 64'(k)) c = 3;
        else if (phave && !ptrap && rvfi_pc_rdata[k*32 +: 32] != ppc) c = 4;
        else if (hb) c = 6;
        ppc = rvfi_pc_wdata[k*32 +: 32];
        ptrap = rvfi_trap[k];
        phave = 1;
        if (rvfi_halt[k]) begin hb = 1; any_halt = 1; end
      end
      if (k == 0 && m_idle == TIMEOUT && !m_halted && (c == 0 || c > 5)) begin
        c = 5; o = m_exp;
      end
      if (c != 0 && best_code == 0) begin
        best_code = c; best_chan = k; best_order = o;
      end
    end
    if (!m_err && best_code != 0) begin
      m_err = 1; m_code = best_code; m_chan = best_chan; m_order = best_order;
    end
    if (n > 0) begin
      m_exp = m_exp + 64'(n);
      m_last_pc = ppc; m_last_trap = ptrap; m_have_last = 1;
      m_cnt = (m_cnt + n > 63) ? 63 : m_cnt + n;
      m_idle = 0;
      if (any_halt) m_halted = 1;
    end else if (!m_halted && m_idle < TIMEOUT) begin
      m_idle++;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_err"}, 64'(err), 64'(m_err));
    chk({tag, "_code"}, 64'(err_code), 64'(m_code));
    chk({tag, "_chan"}, 64'(err_chan), 64'(m_chan));
    chk({tag, "_order"}, err_order, m_order);
    chk({tag, "_cnt"}, 64'(retire_cnt), 64'(m_cnt));
    chk({tag, "_halted"}, 64'(halted), 64'(m_halted));
  endtask

  task automatic chk_out(input string tag, input logic e, input logic [2:0] code, input logic ch,
                         input logic [63:0] ord, input logic [5:0] cnt, input logic h);
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_code"}, 64'(err_code), 64'(code));
    chk({tag, "_chan"}, 64'(err_chan), 64'(ch));
    chk({tag, "_order"}, err_order, ord);
    chk({tag, "_cnt"}, 64'(retire_cnt), 64'(cnt));
    chk({tag, "_halted"}, 64'(halted), 64'(h));
  endtask

  task automatic idle_in();
    rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = '0; rvfi_halt = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; spec_valid = '0; spec_trap = '0;
  endtask

  task automatic set_ch(input int k, input logic [63:0] ord, input logic [31:0] insn,
                        input logic tr, input logic hl, input logic sv, input logic st,
                        input logic [31:0] pcr, input logic [31:0] pcw);
    rvfi_valid[k] = 1'b1;
    rvfi_order[k*64 +: 64] = ord;
    rvfi_insn[k*32 +: 32] = insn;
    rvfi_trap[k] = tr;
    rvfi_halt[k] = hl;
    spec_valid[k] = sv;
    spec_trap[k] = st;
    rvfi_pc_rdata[k*32 +: 32] = pcr;
    rvfi_pc_wdata[k*32 +: 32] = pcw;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_in();
    step();
    resetn = 1'b1;
  endtask

  function automatic vec_t base(input logic [1:0] v);
    vec_t r;
    r.valid = v; r.ord0 = 0; r.ord1 = 1; r.insn0 = ADDI; r.insn1 = ADDI;
    r.trap = 2'b00; r.halt = 2'b00; r.sv = 2'b11; r.st = 2'b00;
    r.pcr0 = 32'h0; r.pcw0 = 32'h4; r.pcr1 = 32'h4; r.pcw1 = 32'h8;
    r.e_err = 0; r.e_code = 0; r.e_chan = 0; r.e_order = 0;
    r.e_cnt = 6'(v[0]) + 6'(v[1]); r.e_halted = 0;
    return r;
  endfunction

  initial begin
    vec_t v;
    logic [63:0] gen_order, ord;
    logic [31:0] gen_pc, pcr, pcw, insn;
    logic [1:0] vmask;
    int r;

    resetn = 1'b0;
    idle_in();

    // Single-cycle vectors, each applied from a fresh reset.
    v = base(2'b01);                                            tbl[0] = v;
    v = base(2'b01); v.insn0 = ADD; v.sv = 2'b10;
    v.e_err = 1; v.e_code = 1;                                  tbl[1] = v;
    v = base(2'b01); v.insn0 = ECALL; v.sv = 2'b10;             tbl[2] = v;
    v = base(2'b01); v.insn0 = ADD; v.sv = 2'b10; v.trap = 2'b01; tbl[3] = v;
    v = base(2'b01); v.st = 2'b01; v.e_err = 1; v.e_code = 1;   tbl[4] = v;
    v = base(2'b10); v.e_err = 1; v.e_code = 2; v.e_chan = 1; v.e_order = 1; tbl[5] = v;
    v = base(2'b11); v.ord1 = 2; v.e_err = 1; v.e_code = 3; v.e_chan = 1; v.e_order = 2; tbl[6] = v;
    v = base(2'b01); v.ord0 = 5; v.e_err = 1; v.e_code = 3; v.e_order = 5; tbl[7] = v;
    v = base(2'b11); v.pcr1 = 32'h8; v.e_err = 1; v.e_code = 4; v.e_chan = 1; v.e_order = 1; tbl[8] = v;
    v = base(2'b11); v.halt = 2'b01; v.e_err = 1; v.e_code = 6; v.e_chan = 1; v.e_order = 1;
    v.e_halted = 1;                                             tbl[9] = v;
    v = base(2'b11); v.halt = 2'b10; v.e_halted = 1;            tbl[10] = v;
    v = base(2'b11); v.insn0 = ADD; v.sv = 2'b10; v.ord1 = 9; v.e_err = 1; v.e_code = 1; tbl[11] = v;
    v = base(2'b10); v.ord1 = 7; v.e_err = 1; v.e_code = 2; v.e_chan = 1; v.e_order = 7; tbl[12] = v;
    v = base(2'b11); v.insn1 = ECALL; v.sv = 2'b01;             tbl[13] = v;
    v = base(2'b01); v.ord0 = 3; v.st = 2'b01; v.e_err = 1; v.e_code = 1; v.e_order = 3; tbl[14] = v;

    do_reset();
    chk_out("reset", 0, 0, 0, 64'd0, 6'd0, 0);

    for (int i = 0; i < NV; i++) begin
      do_reset();
      rvfi_valid = tbl[i].valid; rvfi_order = {tbl[i].ord1, tbl[i].ord0};
      rvfi_insn = {tbl[i].insn1, tbl[i].insn0}; rvfi_trap = tbl[i].trap; rvfi_halt = tbl[i].halt;
      spec_valid = tbl[i].sv; spec_trap = tbl[i].st;
      rvfi_pc_rdata = {tbl[i].pcr1, tbl[i].pcr0}; rvfi_pc_wdata = {tbl[i].pcw1, tbl[i].pcw0};
      step();
      idle_in();
      chk_out($sformatf("vec%0d", i), tbl[i].e_err, tbl[i].e_code, tbl[i].e_chan,
              tbl[i].e_order, tbl[i].e_cnt, tbl[i].e_halted);
      check_model($sformatf("vec%0d_model", i));
    end

    // Four single retirements in sequence.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      set_ch(0, 64'(i), ADDI, 0, 0, 1, 0, 32'(4 * i), 32'(4 * i + 4));
      step();
    end
    idle_in();
    chk_out("seq4", 0, 0, 0, 64'd0, 6'd4, 0);

    // PC continuity across cycles, then the same with the predecessor trapped.
    for (int t = 0; t < 2; t++) begin
      do_reset();
      set_ch(0, 0, ADDI, 0, 0, 1, 0, 32'h0, 32'h4);
      set_ch(1, 1, ADDI, 1'(t), 0, 1, 0, 32'h4, 32'h100);
      step();
      idle_in();
      set_ch(0, 2, ADDI, 0, 0, 1, 0, 32'h104, 32'h108);
      step();
      idle_in();
      if (t == 0) chk_out("pc_xcycle", 1, 3'd4, 0, 64'd2, 6'd3, 0);
      else        chk_out("pc_xcycle_trap", 0, 0, 0, 64'd0, 6'd3, 0);
    end

    // Liveness: one retirement, then idle until the window expires.
    do_reset();
    set_ch(0, 0, ADDI, 0, 0, 1, 0, 32'h0, 32'h4);
    step();
    idle_in();
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("timeout_idle%0d", i), 64'(err), 64'(i == 17));
    end
    chk_out("timeout", 1, 3'd5, 0, 64'd1, 6'd1, 0);
    set_ch(0, 9, ADD, 0, 0, 0, 0, 32'h40, 32'h44);
    step();
    idle_in();
    chk_out("sticky", 1, 3'd5, 0, 64'd1, 6'd2, 0);

    // Halt suppresses the timeout; a later retirement is an error.
    do_reset();
    set_ch(0, 0, ADDI, 0, 1, 1, 0, 32'h0, 32'h4);
    step();
    idle_in();
    for (int i = 0; i < 100; i++) step();
    chk_out("halt_idle", 0, 0, 0, 64'd0, 6'd1, 1);
    set_ch(0, 1, ADDI, 0, 0, 1, 0, 32'h4, 32'h8);
    step();
    idle_in();
    chk_out("after_halt", 1, 3'd6, 0, 64'd1, 6'd2, 1);

    // Reset mid-operation discards the latched error and ignores inputs.
    do_reset();
    set_ch(0, 5, ADDI, 0, 0, 1, 0, 32'h0, 32'h4);
    step();
    chk("pre_reset_err", 64'(err), 64'd1);
    resetn = 1'b0;
    idle_in();
    set_ch(0, 9, ADD, 0, 0, 0, 0, 32'h80, 32'h84);
    step();
    chk_out("mid_reset", 0, 0, 0, 64'd0, 6'd0, 0);
    resetn = 1'b1;
    idle_in();
    set_ch(0, 0, ADDI, 0, 0, 1, 0, 32'h40, 32'h44);
    step();
    idle_in();
    chk_out("post_reset", 0, 0, 0, 64'd0, 6'd1, 0);

    // Retire counter saturation.
    do_reset();
    for (int i = 0; i < 35; i++) begin
      idle_in();
      set_ch(0, 64'(2 * i), ADDI, 0, 0, 1, 0, 32'(8 * i), 32'(8 * i + 4));
      set_ch(1, 64'(2 * i + 1), ADDI, 0, 0, 1, 0, 32'(8 * i + 4), 32'(8 * i + 8));
      step();
    end
    idle_in();
    chk_out("saturate", 0, 0, 0, 64'd0, 6'd63, 0);

    // Randomized traffic against the reference model.
    do_reset();
    gen_order = 0;
    gen_pc = 0;
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      if ($urandom_range(0, 59) == 0) begin
        resetn = 1'b0;
        gen_order = 0;
        gen_pc = 0;
        set_ch(0, 64'($urandom), ADD, 0, 1, 0, 0, $urandom, $urandom);
      end else begin
        resetn = 1'b1;
        r = $urandom_range(0, 99);
        vmask = (r < 30) ? 2'b00 : (r < 60) ? 2'b01 : (r < 97) ? 2'b11 : 2'b10;
        for (int k = 0; k < 2; k++) begin
          if (vmask[k]) begin
            ord = gen_order + 64'(k);
            if ($urandom_range(0, 49) == 0) ord = ord + 64'($urandom_range(1, 3));
            pcr = gen_pc;
            if ($urandom_range(0, 49) == 0) pcr = pcr ^ 32'h10;
            pcw = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFFFF_FFFC) : pcr + 32'h4;
            r = $urandom_range(0, 9);
            insn = (r < 7) ? ADDI : (r < 9) ? ADD : ECALL;
            set_ch(k, ord, insn, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0),
                   1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 29) == 0), pcr, pcw);
            gen_pc = pcw;
          end
        end
        gen_order = gen_order + 64'(vmask[0]) + 64'(vmask[1]);
      end
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_monitor.md
Name: rvfi_retire_monitor

Overview:
- Synthesizable RVFI retirement monitor for formal and simulation benches around minrv32 and its multi-retire successors.
- Supports NRET retirement channels. Fed by the core's RVFI outputs and by one rvfi_isa_rv32i spec instance per channel.
- Checks the following on every retirement: spec completeness, order contiguity, PC continuity, retire-after-halt, and a liveness timeout.
- Captures the first violation in sticky registers and counts retirements.

Parameters:
- NRET, 1, number of retirement channels per cycle.
- XLEN, 32, register/PC width.
- TIMEOUT, 16, maximum consecutive cycles without a retirement before a liveness error; 0 disables the check.
- CNT_W, 32, retire counter width.
- SKIP_SYSTEM, 1, when 1, the completeness check is skipped for opcode 7'b1110011.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, synchronous active-low reset.
- rvfi_valid, input, NRET, per-channel retire strobe.
- rvfi_order, input, 64*NRET, per-channel retirement index.
- rvfi_insn, input, 32*NRET, retired instruction word.
- rvfi_trap, input, NRET, instruction trapped.
- rvfi_halt, input, NRET, last instruction before halt.
- rvfi_pc_rdata, input, XLEN*NRET, PC of the instruction.
- rvfi_pc_wdata, input, XLEN*NRET, next PC.
- spec_valid, input, NRET, spec model recognises the instruction.
- spec_trap, input, NRET, spec model says the instruction traps.
- err, output, 1, sticky error flag.
- err_code, output, 3, code of the first error.
- err_chan, output, max(1,$clog2(NRET)), channel of the first error.
- err_order, output, 64, rvfi_order of the first offending retirement.
- retire_cnt, output, CNT_W, saturating count of retirements.
- halted, output, 1, a halt retirement has been seen.

Behaviour:
- Reset: clk is the clock; resetn is synchronous and active-low.
  - While resetn is low, all inputs are ignored.
  - Reset clears: err=0, err_code=0, err_chan=0, err_order=0, retire_cnt=0, halted=0, expected order=0, last_pc_valid=0, idle counter=0.
  - Reset mid-operation discards all history. The first retirement after reset is never PC-checked and must carry order 0.
- Per cycle, with channel k active when rvfi_valid[k]=1, error codes are:
  - 1 INCOMPLETE: !rvfi_trap[k] && !(SKIP_SYSTEM && insn[6:0]==7'b1110011) && !(spec_valid[k] && !spec_trap[k]).
  - 2 GAP: rvfi_valid[k] && !rvfi_valid[k-1] for k>0. Active channels must be packed lowest-first.
  - 3 ORDER: rvfi_order[k] != expected_order + k.
  - 4 PC: pc_rdata[k] != predecessor pc_wdata.
    - The predecessor is channel k-1 in the same cycle, or the last active channel of the most recent retiring cycle.
    - Skipped when no predecessor exists since reset, or when the predecessor trapped.
  - 5 TIMEOUT: the idle counter reaches TIMEOUT while !halted. Reported with err_chan=0 and err_order = expected_order.
  - 6 AFTER_HALT: any valid while halted=1, or a valid on channel j>k in the same cycle as rvfi_halt[k].
- Priority when several violations occur in one cycle: lowest channel first, then lowest code.
- Error capture:
  - The first violation is registered and visible the cycle after the offending retirement (latency 1).
  - Later violations are ignored until reset. err stays high.
- State update on a retiring cycle (regardless of errors):
  - expected_order += popcount(rvfi_valid).
  - last_pc takes pc_wdata of the highest active channel; last_trap takes its trap bit; last_pc_valid=1.
  - retire_cnt += popcount, saturating at 2^CNT_W-1.
  - Idle counter cleared.
  - halted is set if any active channel has rvfi_halt.
- State update on a non-retiring cycle: the idle counter increments, saturating at TIMEOUT. It does not count while halted or when TIMEOUT=0.
- Fully synchronous. No combinational input-to-output paths.

Test Plan:
- NRET=1: retire order 0..3, PCs 0x0,0x4,0x8,0xC with pc_wdata=pc+4, spec_valid=1 -> err=0, retire_cnt=4.
- NRET=1: retirement with insn=0x00000033, spec_valid=0, trap=0 -> err=1, err_code=1, err_order as given, one cycle later. Same stimulus with insn=0x00000073 and SKIP_SYSTEM=1 -> err=0.
- NRET=2:
  - valid=2'b10 -> err_code=2, err_chan=1.
  - valid=2'b11 with orders 0,2 -> err_code=3, err_chan=1.
- NRET=2: cycle A channel 1 pc_wdata=0x100; next cycle channel 0 pc_rdata=0x104 -> err_code=4, err_chan=0. Same stimulus with channel 1 trapped in cycle A -> no error.
- TIMEOUT=16: one retirement then 16 idle cycles -> err_code=5 on the cycle after the counter reaches 16. Halt retirement then 100 idle cycles -> no error. Any retirement after the halt -> err_code=6.
- Error latched, then resetn=0 for one cycle, then a clean retirement at order 0 -> all outputs at reset values, then retire_cnt=1, err=0. A further error during reset is ignored.
